// File: rtl/pwm_generate.sv
// Periodic PWM generator with double-buffered high/period configuration.
// Optional one-shot mode (trigger/done ports) is enabled by defining PWM_ONESHOT_EN.
module pwm_generate #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_high,
    input  logic [WIDTH-1:0] cfg_period,
`ifdef PWM_ONESHOT_EN
    input  logic             trigger,
    output logic             done,
`endif
    output logic             pwm_out,
    output logic             period_start,
    output logic             cfg_error
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] pend_high_q, pend_high_d;
    logic [WIDTH-1:0] pend_period_q, pend_period_d;
    logic             pend_full_q, pend_full_d;
    logic             pwm_q, pwm_d;
    logic             ps_q, ps_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;

    logic xfer;
    logic cfg_ok;
    logic at_wrap;
    logic go;

    assign xfer    = cfg_valid && ready_q;
    assign cfg_ok  = (cfg_period != '0);
    assign at_wrap = (state_q == RUN) && (count_q == (period_q - WIDTH'(1)));

`ifdef PWM_ONESHOT_EN
    logic oneshot_q, oneshot_d;
    logic done_q, done_d;
    assign go = (period_q != '0) && (enable || trigger);
`else
    assign go = (period_q != '0) && enable;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            count_q       <= '0;
            high_q        <= '0;
            period_q      <= '0;
            pend_high_q   <= '0;
            pend_period_q <= '0;
            pend_full_q   <= 1'b0;
            pwm_q         <= 1'b0;
            ps_q          <= 1'b0;
            err_q         <= 1'b0;
            ready_q       <= 1'b1;
`ifdef PWM_ONESHOT_EN
            oneshot_q     <= 1'b0;
            done_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            high_q        <= high_d;
            period_q      <= period_d;
            pend_high_q   <= pend_high_d;
            pend_period_q <= pend_period_d;
            pend_full_q   <= pend_full_d;
            pwm_q         <= pwm_d;
            ps_q          <= ps_d;
            err_q         <= err_d;
            ready_q       <= ready_d;
`ifdef PWM_ONESHOT_EN
            oneshot_q     <= oneshot_d;
            done_q        <= done_d;
`endif
        end
    end

    // Next-state: period counter, boundary swap of pending config, config intake
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        high_d        = high_q;
        period_d      = period_q;
        pend_high_d   = pend_high_q;
        pend_period_d = pend_period_q;
        pend_full_d   = pend_full_q;
`ifdef PWM_ONESHOT_EN
        oneshot_d     = oneshot_q;
`endif
        unique case (state_q)
            IDLE: begin
                count_d = '0;
                if (go) begin
                    state_d = RUN;
`ifdef PWM_ONESHOT_EN
                    oneshot_d = !enable;
`endif
                end
            end
            RUN: begin
                if (at_wrap) begin
                    count_d = '0;
                    if (pend_full_q) begin
                        high_d      = pend_high_q;
                        period_d    = pend_period_q;
                        pend_full_d = 1'b0;
                    end
                    if (!enable) begin
                        state_d = IDLE;
                    end
`ifdef PWM_ONESHOT_EN
                    oneshot_d = 1'b0;
`endif
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A config accepted while idle goes straight to active; while running it waits
        if (xfer && cfg_ok) begin
            if (state_q == IDLE) begin
                high_d   = cfg_high;
                period_d = cfg_period;
            end else begin
                pend_high_d   = cfg_high;
                pend_period_d = cfg_period;
                pend_full_d   = 1'b1;
            end
        end
    end

    // Outputs are computed from next-state values so the registers line up with count
    always_comb begin
        pwm_d   = (state_d == RUN) && (count_d < high_d);
        ps_d    = (state_d == RUN) && (count_d == '0);
        err_d   = xfer && !cfg_ok;
        ready_d = !pend_full_d;
`ifdef PWM_ONESHOT_EN
        done_d  = at_wrap && !enable && oneshot_q;
`endif
    end

    assign pwm_out      = pwm_q;
    assign period_start = ps_q;
    assign cfg_error    = err_q;
    assign cfg_ready    = ready_q;
`ifdef PWM_ONESHOT_EN
    assign done         = done_q;
`endif

endmodule
